// File: rtl/datapath.sv
// Single-bus 32-bit datapath: register file, HI/LO, PC, IR, Y, Z, MAR, MDR.
// One combinational bus feeds every register load and ALU operand B.
module datapath (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] gpr_in,
  input  logic [15:0] gpr_out,
  input  logic        hi_in,
  input  logic        lo_in,
  input  logic        hi_out,
  input  logic        lo_out,
  input  logic        pc_in,
  input  logic        pc_out,
  input  logic        ir_in,
  input  logic        z_in,
  input  logic        z_high_out,
  input  logic        z_low_out,
  input  logic        inport_out,
  input  logic        c_out,
  input  logic        y_in,
  input  logic        mar_in,
  input  logic        mdr_in,
  input  logic        mdr_out,
  input  logic        read,
  input  logic [31:0] m_data_in,
  input  logic [3:0]  alu_op,
  input  logic        inc_pc,
  output logic [31:0] bus_data
);

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_OR  = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_SHR = 4'h4, OP_SHL = 4'h5, OP_ROR = 4'h6, OP_ROL = 4'h7,
    OP_MUL = 4'h8, OP_DIV = 4'h9, OP_NEG = 4'hA, OP_NOT = 4'hB
  } alu_op_e;

  logic [31:0] r_gpr [16];
  logic [31:0] r_hi, r_lo, r_pc, r_ir, r_y, r_mar, r_mdr, r_inport;
  logic [63:0] r_z;

  logic [31:0] w_bus, w_c;
  logic [4:0]  w_sh;
  logic [63:0] w_alu, w_rr, w_rl;
  logic signed [63:0] w_a64, w_b64, w_dv64;
  logic signed [63:0] w_prod, w_quo, w_rem;
  logic        w_unused;

  assign w_c = {{13{r_ir[18]}}, r_ir[18:0]};

  // Later assignments win, so the list runs lowest to highest priority.
  always_comb begin
    w_bus = '0;
    if (c_out)      w_bus = w_c;
    if (inport_out) w_bus = r_inport;
    if (mdr_out)    w_bus = r_mdr;
    if (pc_out)     w_bus = r_pc;
    if (z_low_out)  w_bus = r_z[31:0];
    if (z_high_out) w_bus = r_z[63:32];
    if (lo_out)     w_bus = r_lo;
    if (hi_out)     w_bus = r_hi;
    for (int i = 15; i >= 0; i--)
      if (gpr_out[i]) w_bus = r_gpr[i];
  end

  assign bus_data = w_bus;

  assign w_sh   = w_bus[4:0];
  assign w_a64  = {{32{r_y[31]}}, r_y};
  assign w_b64  = {{32{w_bus[31]}}, w_bus};
  // Divisor forced nonzero; the zero case is patched in the ALU mux.
  assign w_dv64 = (w_bus == '0) ? 64'sd1 : w_b64;
  assign w_prod = w_a64 * w_b64;
  assign w_quo  = w_a64 / w_dv64;
  assign w_rem  = w_a64 % w_dv64;
  assign w_rr   = {r_y, r_y} >> w_sh;
  assign w_rl   = {r_y, r_y} << w_sh;

  always_comb begin
    w_alu = '0;
    if (inc_pc) begin
      w_alu[31:0] = w_bus + 32'd1;
    end else begin
      case (alu_op)
        OP_AND: w_alu[31:0] = r_y & w_bus;
        OP_OR:  w_alu[31:0] = r_y | w_bus;
        OP_ADD: w_alu[31:0] = r_y + w_bus;
        OP_SUB: w_alu[31:0] = r_y - w_bus;
        OP_SHR: w_alu[31:0] = r_y >> w_sh;
        OP_SHL: w_alu[31:0] = r_y << w_sh;
        OP_ROR: w_alu[31:0] = w_rr[31:0];
        OP_ROL: w_alu[31:0] = w_rl[63:32];
        OP_MUL: w_alu = w_prod;
        OP_DIV: begin
          if (w_bus == '0) w_alu = {r_y, 32'hFFFF_FFFF};
          else             w_alu = {w_rem[31:0], w_quo[31:0]};
        end
        OP_NEG: w_alu[31:0] = -w_bus;
        OP_NOT: w_alu[31:0] = ~w_bus;
        default: w_alu = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_pc     <= '0;
      r_ir     <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_mar    <= '0;
      r_mdr    <= '0;
      r_inport <= '0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (gpr_in[i]) r_gpr[i] <= w_bus;
      if (hi_in)  r_hi  <= w_bus;
      if (lo_in)  r_lo  <= w_bus;
      if (pc_in)  r_pc  <= w_bus;
      if (ir_in)  r_ir  <= w_bus;
      if (y_in)   r_y   <= w_bus;
      if (z_in)   r_z   <= w_alu;
      if (mar_in) r_mar <= w_bus;
      if (mdr_in) r_mdr <= read ? m_data_in : w_bus;
    end
  end

  // MAR and the IR decode fields feed logic outside this block.
  assign w_unused = ^{r_mar, r_ir[31:19], w_rr[63:32], w_rl[31:0],
                      w_quo[63:32], w_rem[63:32]};

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: every register is observed via the bus.
// Expected values are hand-computed constants.
module tb_datapath;

  logic        clk = 0;
  logic        reset_n;
  logic [15:0] gpr_in, gpr_out;
  logic        hi_in, lo_in, hi_out, lo_out, pc_in, pc_out, ir_in;
  logic        z_in, z_high_out, z_low_out, inport_out, c_out;
  logic        y_in, mar_in, mdr_in, mdr_out, read;
  logic [31:0] m_data_in;
  logic [3:0]  alu_op;
  logic        inc_pc;
  logic [31:0] bus_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  datapath dut (
    .clk(clk), .reset_n(reset_n),
    .gpr_in(gpr_in), .gpr_out(gpr_out),
    .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
    .pc_in(pc_in), .pc_out(pc_out), .ir_in(ir_in),
    .z_in(z_in), .z_high_out(z_high_out), .z_low_out(z_low_out),
    .inport_out(inport_out), .c_out(c_out),
    .y_in(y_in), .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .read(read), .m_data_in(m_data_in), .alu_op(alu_op),
    .inc_pc(inc_pc), .bus_data(bus_data)
  );

  task automatic clr();
    reset_n = 0; gpr_in = '0; gpr_out = '0;
    hi_in = 0; lo_in = 0; hi_out = 0; lo_out = 0;
    pc_in = 0; pc_out = 0; ir_in = 0; z_in = 0;
    z_high_out = 0; z_low_out = 0; inport_out = 0; c_out = 0;
    y_in = 0; mar_in = 0; mdr_in = 0; mdr_out = 0; read = 0;
    m_data_in = '0; alu_op = '0; inc_pc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic chk(input string tag, input logic [31:0] exp);
    #1;
    checks++;
    assert (bus_data === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, bus_data, exp);
    end
    clr();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    m_data_in = v; read = 1; mdr_in = 1;
    tick();
  endtask

  task automatic set_gpr(input int i, input logic [31:0] v);
    load_mdr(v);
    mdr_out = 1; gpr_in[i] = 1;
    tick();
  endtask

  task automatic set_y(input logic [31:0] v);
    load_mdr(v);
    mdr_out = 1; y_in = 1;
    tick();
  endtask

  task automatic alu(input int src, input logic [3:0] op);
    gpr_out[src] = 1; alu_op = op; z_in = 1;
    tick();
  endtask

  task automatic chk_gpr(input string tag, input int i, input logic [31:0] e);
    gpr_out[i] = 1;
    chk(tag, e);
  endtask

  task automatic chk_z(input string tag, input logic [63:0] e);
    z_high_out = 1;
    chk({tag, "_hi"}, e[63:32]);
    z_low_out = 1;
    chk({tag, "_lo"}, e[31:0]);
  endtask

  initial begin
    clr();
    reset_n = 1;
    tick();

    chk("rst_bus_idle", 32'h0);
    chk_gpr("rst_r0", 0, 32'h0);
    chk_gpr("rst_r15", 15, 32'h0);
    hi_out = 1;     chk("rst_hi", 32'h0);
    lo_out = 1;     chk("rst_lo", 32'h0);
    pc_out = 1;     chk("rst_pc", 32'h0);
    mdr_out = 1;    chk("rst_mdr", 32'h0);
    inport_out = 1; chk("rst_inport", 32'h0);
    c_out = 1;      chk("rst_c", 32'h0);
    chk_z("rst_z", 64'h0);

    set_gpr(2, 32'h22);
    set_gpr(4, 32'h24);
    set_gpr(5, 32'hFF);
    chk_gpr("ld_r2", 2, 32'h22);
    chk_gpr("ld_r4", 4, 32'h24);
    chk_gpr("ld_r5", 5, 32'hFF);

    pc_out = 1; mar_in = 1; inc_pc = 1; z_in = 1; alu_op = 4'h2;
    tick();
    chk_z("inc_pc", 64'h1);
    z_low_out = 1; pc_in = 1;
    tick();
    pc_out = 1; chk("pc_inc", 32'h1);
    load_mdr(32'h8A90_0000);
    mdr_out = 1; chk("mdr_fetch", 32'h8A90_0000);
    mdr_out = 1; ir_in = 1;
    tick();
    c_out = 1; chk("c_fetch_ir", 32'h0);

    alu(2, 4'hB);
    z_low_out = 1; gpr_in[5] = 1;
    tick();
    chk_gpr("not_r5", 5, 32'hFFFF_FFDD);

    set_y(32'hFFFF_FFFE);
    set_gpr(6, 32'h3);
    alu(6, 4'h8);
    chk_z("mul", 64'hFFFF_FFFF_FFFF_FFFA);

    set_y(32'h7);
    set_gpr(6, 32'h2);
    alu(6, 4'h9);
    chk_z("div", {32'h1, 32'h3});
    alu(0, 4'h9);
    chk_z("div0", {32'h7, 32'hFFFF_FFFF});
    set_y(32'hFFFF_FFF9);
    alu(6, 4'h9);
    chk_z("div_neg", {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    set_y(32'h8000_0001);
    set_gpr(6, 32'h1);
    alu(6, 4'h6); chk_z("ror", {32'h0, 32'hC000_0000});
    alu(6, 4'h4); chk_z("shr", {32'h0, 32'h4000_0000});
    alu(6, 4'h7); chk_z("rol", {32'h0, 32'h0000_0003});
    alu(6, 4'h5); chk_z("shl", {32'h0, 32'h0000_0002});
    alu(6, 4'h2); chk_z("add", {32'h0, 32'h8000_0002});
    alu(6, 4'h3); chk_z("sub", {32'h0, 32'h8000_0000});
    alu(6, 4'h0); chk_z("and", {32'h0, 32'h0000_0001});
    alu(6, 4'h1); chk_z("or",  {32'h0, 32'h8000_0001});
    alu(6, 4'hA); chk_z("neg", {32'h0, 32'hFFFF_FFFF});
    alu(6, 4'hC); chk_z("op_c", 64'h0);
    set_y(32'hFFFF_FFFF);
    alu(6, 4'h2); chk_z("add_wrap", 64'h0);

    load_mdr(32'h0007_FFFF);
    mdr_out = 1; ir_in = 1;
    tick();
    c_out = 1; chk("c_neg", 32'hFFFF_FFFF);
    load_mdr(32'h0003_FFFF);
    mdr_out = 1; ir_in = 1;
    tick();
    c_out = 1; chk("c_pos", 32'h0003_FFFF);

    gpr_out[4] = 1; hi_in = 1;
    tick();
    gpr_out[5] = 1; lo_in = 1;
    tick();
    hi_out = 1; c_out = 1; chk("prio_hi_c", 32'h24);
    lo_out = 1; pc_out = 1; chk("prio_lo_pc", 32'hFFFF_FFDD);
    gpr_out[2] = 1; gpr_out[5] = 1; hi_out = 1;
    chk("prio_r2", 32'h22);

    mdr_out = 1; mdr_in = 1; read = 0;
    tick();
    mdr_out = 1; chk("mdr_self", 32'h0003_FFFF);

    reset_n = 1; mdr_out = 1; gpr_in[2] = 1;
    tick();
    chk_gpr("rst_wins", 2, 32'h0);
    hi_out = 1; chk("rst_hi2", 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
